// File: rtl/mips16_pkg.sv
// mips16_pkg: shared data-path widths and store-buffer defaults
package mips16_pkg;
  localparam int SB_ADDR_W = 16;
  localparam int SB_DATA_W = 16;
  localparam int SB_DEPTH = 4;
  typedef enum logic [1:0] {PORT_IDLE, PORT_LOAD, PORT_DRAIN} port_op_e;
endpackage

// File: rtl/sb_fifo.sv
// sb_fifo: circular store storage with head/tail pointers and occupancy count
module sb_fifo
  import mips16_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic [PW-1:0]     head,
  output logic [CW-1:0]     count,
  output logic [ADDR_W-1:0] addr_q [DEPTH],
  output logic [DATA_W-1:0] data_q [DEPTH]
);
  logic [PW-1:0] tail;
  always_ff @(posedge clock)
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(pop);
      tail <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clock)
    if (push) begin
      addr_q[tail] <= push_addr;
      data_q[tail] <= push_data;
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: write buffer between MEM stage and data memory; loads win the port.
// STORE_BUF_FWD_EN enables store-to-load forwarding, otherwise matching loads stall.
module store_buffer
  import mips16_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              stall,
  output logic              mem_rm,
  output logic              mem_wm,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              empty,
  output logic [CW-1:0]     count
);
  logic [PW-1:0] head, idx;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic full, busy, ld_acc, push, pop, hit;
  logic [DATA_W-1:0] hit_data;
  port_op_e op;
  sb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
    .clock(clock), .reset_n(reset_n), .push(push), .pop(pop),
    .push_addr(cpu_addr), .push_data(cpu_wdata),
    .head(head), .count(count), .addr_q(addr_q), .data_q(data_q)
  );
  // walk oldest to youngest so the last match wins
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && addr_q[idx] == cpu_addr) begin
        hit = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
`ifdef STORE_BUF_FWD_EN
  assign stall = cpu_wr & full;
`else
  assign stall = cpu_wr ? full : cpu_rd & hit;
`endif
  // an unstalled cpu_rd owns the port even when paired with a store, holding drains off
  assign busy = reset_n & cpu_rd & ~stall;
  assign ld_acc = busy & ~cpu_wr;
  assign push = reset_n & cpu_wr & ~full;
  assign pop = reset_n & ~busy & ~empty;
  assign op = ld_acc ? PORT_LOAD : pop ? PORT_DRAIN : PORT_IDLE;
  assign mem_rm = op == PORT_LOAD;
  assign mem_wm = op == PORT_DRAIN;
  assign mem_addr = op == PORT_LOAD ? cpu_addr : op == PORT_DRAIN ? addr_q[head] : '0;
  assign mem_wdata = op == PORT_DRAIN ? data_q[head] : '0;
  always_ff @(posedge clock)
    if (!reset_n) begin
      cpu_rdata <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= ld_acc;
      if (ld_acc) cpu_rdata <= hit ? hit_data : mem_rdata;
    end
endmodule
